// File: rtl/axi_ar_request_builder.sv
// Turns one decoded memory-read TLP into one AXI AR FIFO entry using an IDLE/CALC/PUSH sequence.
// Optional build macro AR_ADDR_ALIGN_EN: ARADDR is aligned down to the 128-byte beat.
module axi_ar_request_builder #(
    parameter int unsigned ADDR_WIDTH        = 64,
    parameter int unsigned ID_WIDTH          = 10,
    parameter int unsigned AR_CHANNEL_WIDTH  = 120,
    parameter int unsigned ADDR_LSBS_PORTION = 5
) (
    input  logic                        i_clk,
    input  logic                        i_n_rst,
    input  logic                        i_req_valid,
    output logic                        o_req_ready,
    input  logic [ADDR_WIDTH-1:0]       i_req_addr,
    input  logic [9:0]                  i_req_length,
    input  logic [ID_WIDTH-1:0]         i_req_tag,
    input  logic [15:0]                 i_req_requester_id,
    input  logic [2:0]                  i_req_tc,
    input  logic [3:0]                  i_req_fbe,
    input  logic [3:0]                  i_req_lbe,
    output logic [AR_CHANNEL_WIDTH-1:0] o_AR_CHANNEL_fifo,
    output logic                        o_ar_ch_fifo_write_inc,
    input  logic                        i_ar_ch_fifo_full,
    output logic                        o_busy
);

    localparam int unsigned LEN_W   = 10;
    localparam int unsigned TOTAL_W = 11;
    localparam int unsigned ARLEN_W = 8;
    localparam int unsigned OFF_W   = ADDR_LSBS_PORTION;
    localparam int unsigned ADDR_Q_W = ADDR_WIDTH - 2;
    localparam int unsigned ENTRY_W = ID_WIDTH + ADDR_WIDTH + ARLEN_W + 4 + 16 + 4 + 4 + 2 * OFF_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        PUSH = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   accept_c, push_c;
    logic   ready_q, busy_q;

    logic [ADDR_Q_W-1:0] addr_q;
    logic [LEN_W-1:0]    len_q;
    logic [ID_WIDTH-1:0] tag_q;
    logic [15:0]         rid_q;
    logic [2:0]          tc_q;
    logic [3:0]          fbe_q, lbe_q;
    logic [ENTRY_W-1:0]  entry_q, entry_c;

    logic [OFF_W-1:0]      off_c, last_dw_c;
    logic [TOTAL_W-1:0]    len_c, total_c, total_m1_c;
    logic [ARLEN_W-1:0]    arlen_c;
    logic [ADDR_WIDTH-1:0] araddr_c;

    // Byte lane bits of the address never reach the AR channel.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^i_req_addr[1:0];

    // State register plus registered handshake/status outputs.
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
        end
    end

    // Next-state and strobe decode; the strobe follows full combinationally in PUSH.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        push_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    accept_c = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: state_d = PUSH;
            PUSH: begin
                if (!i_ar_ch_fifo_full) begin
                    push_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture on handshake.
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            addr_q <= '0;
            len_q  <= '0;
            tag_q  <= '0;
            rid_q  <= '0;
            tc_q   <= '0;
            fbe_q  <= '0;
            lbe_q  <= '0;
        end else if (accept_c) begin
            addr_q <= i_req_addr[ADDR_WIDTH-1:2];
            len_q  <= i_req_length;
            tag_q  <= i_req_tag;
            rid_q  <= i_req_requester_id;
            tc_q   <= i_req_tc;
            fbe_q  <= i_req_fbe;
            lbe_q  <= i_req_lbe;
        end
    end

    // Beat arithmetic: DW offset in the first beat plus length gives beats spanned and last DW.
    always_comb begin
        off_c      = addr_q[OFF_W-1:0];
        len_c      = (len_q == '0) ? TOTAL_W'(1024) : TOTAL_W'(len_q);
        total_c    = TOTAL_W'(off_c) + len_c;
        total_m1_c = total_c - TOTAL_W'(1);
        arlen_c    = ARLEN_W'(total_m1_c >> OFF_W);
        last_dw_c  = total_m1_c[OFF_W-1:0];
`ifdef AR_ADDR_ALIGN_EN
        araddr_c   = {addr_q[ADDR_Q_W-1:OFF_W], (OFF_W + 2)'(0)};
`else
        araddr_c   = {addr_q, 2'b00};
`endif
        entry_c    = {tag_q, araddr_c, arlen_c, 1'b0, tc_q, rid_q, fbe_q, lbe_q, off_c, last_dw_c};
    end

    // Entry is loaded once on CALC exit and held through any backpressure.
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            entry_q <= '0;
        end else if (state_q == CALC) begin
            entry_q <= entry_c;
        end
    end

    assign o_req_ready            = ready_q;
    assign o_busy                 = busy_q;
    assign o_ar_ch_fifo_write_inc = push_c;
    assign o_AR_CHANNEL_fifo      = AR_CHANNEL_WIDTH'(entry_q);

endmodule

// File: tb/tb_axi_ar_request_builder.sv
// Bench for axi_ar_request_builder: directed scenarios plus random traffic against a cycle-level model.
module tb_axi_ar_request_builder;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [63:0]  req_addr;
    logic [9:0]   req_length;
    logic [9:0]   req_tag;
    logic [15:0]  req_rid;
    logic [2:0]   req_tc;
    logic [3:0]   req_fbe;
    logic [3:0]   req_lbe;
    logic [119:0] entry;
    logic         wr_inc;
    logic         fifo_full;
    logic         busy;

    int total_cnt = 0;
    int bad_cnt   = 0;

    axi_ar_request_builder dut (
        .i_clk                  (clk),
        .i_n_rst                (rst_n),
        .i_req_valid            (req_valid),
        .o_req_ready            (req_ready),
        .i_req_addr             (req_addr),
        .i_req_length           (req_length),
        .i_req_tag              (req_tag),
        .i_req_requester_id     (req_rid),
        .i_req_tc               (req_tc),
        .i_req_fbe              (req_fbe),
        .i_req_lbe              (req_lbe),
        .o_AR_CHANNEL_fifo      (entry),
        .o_ar_ch_fifo_write_inc (wr_inc),
        .i_ar_ch_fifo_full      (fifo_full),
        .o_busy                 (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        total_cnt++;
        if (got !== want) begin
            bad_cnt++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference entry built from plain integer arithmetic on the request fields.
    function automatic logic [119:0] exp_entry(input logic [63:0] a, input logic [9:0] l,
                                               input logic [9:0] t, input logic [15:0] rid,
                                               input logic [2:0] tc, input logic [3:0] fb,
                                               input logic [3:0] lb);
        int unsigned  off, len, tot, arlen, last;
        logic [63:0]  araddr;
        logic [119:0] e;
        off   = int'((a % 64'd128) / 64'd4);
        len   = (l == 10'd0) ? 1024 : int'(l);
        tot   = off + len;
        arlen = (tot + 31) / 32 - 1;
        last  = (tot - 1) % 32;
`ifdef AR_ADDR_ALIGN_EN
        araddr = a - (a % 64'd128);
`else
        araddr = a - (a % 64'd4);
`endif
        e = '0;
        e[119:110] = t;
        e[109:46]  = araddr;
        e[45:38]   = 8'(arlen);
        e[37:34]   = {1'b0, tc};
        e[33:18]   = rid;
        e[17:14]   = fb;
        e[13:10]   = lb;
        e[9:5]     = 5'(off);
        e[4:0]     = 5'(last);
        return e;
    endfunction

    // Model: one outstanding request; strobe allowed from the second cycle after accept when not full.
    logic         pending = 1'b0;
    int           age     = 0;
    logic [119:0] exp_cur = '0;
    logic         exp_strobe;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_ready", 128'(req_ready), 128'(1));
            check("rst_busy", 128'(busy), 128'(0));
            check("rst_strobe", 128'(wr_inc), 128'(0));
            check("rst_entry", 128'(entry), 128'(0));
            pending = 1'b0;
            age     = 0;
        end else begin
            exp_strobe = pending && (age >= 1) && !fifo_full;
            check("strobe", 128'(wr_inc), 128'(exp_strobe));
            check("ready", 128'(req_ready), 128'(!pending));
            check("busy", 128'(busy), 128'(pending));
            if (pending && age >= 1) check("entry", 128'(entry), 128'(exp_cur));
            if (pending) begin
                if (exp_strobe) pending = 1'b0;
                else age++;
            end else if (req_valid) begin
                pending = 1'b1;
                age     = 0;
                exp_cur = exp_entry(req_addr, req_length, req_tag, req_rid, req_tc, req_fbe, req_lbe);
            end
        end
    end

    task automatic drive_req(input logic [63:0] a, input logic [9:0] l, input logic [9:0] t);
        req_valid  = 1'b1;
        req_addr   = a;
        req_length = l;
        req_tag    = t;
        req_rid    = 16'($urandom);
        req_tc     = 3'($urandom);
        req_fbe    = 4'($urandom);
        req_lbe    = 4'($urandom);
    endtask

    task automatic run_one(input string nm, input logic [63:0] a, input logic [9:0] l,
                           input logic [9:0] t, input logic [7:0] x_arlen, input logic [4:0] x_off,
                           input logic [4:0] x_last, input logic [63:0] x_addr);
        @(posedge clk); #1;
        drive_req(a, l, t);
        @(negedge clk);
        check({nm, "_ready"}, 128'(req_ready), 128'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check({nm, "_calc_strobe"}, 128'(wr_inc), 128'(0));
        @(negedge clk);
        check({nm, "_push_strobe"}, 128'(wr_inc), 128'(1));
        check({nm, "_arid"}, 128'(entry[119:110]), 128'(t));
        check({nm, "_araddr"}, 128'(entry[109:46]), 128'(x_addr));
        check({nm, "_arlen"}, 128'(entry[45:38]), 128'(x_arlen));
        check({nm, "_off"}, 128'(entry[9:5]), 128'(x_off));
        check({nm, "_last_dw"}, 128'(entry[4:0]), 128'(x_last));
        @(negedge clk);
        check({nm, "_idle_ready"}, 128'(req_ready), 128'(1));
    endtask

    logic [63:0]  a_tmp;
    logic [119:0] e_tmp;

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_length = '0;
        req_tag    = '0;
        req_rid    = '0;
        req_tc     = '0;
        req_fbe    = '0;
        req_lbe    = '0;
        fifo_full  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", 128'(req_ready), 128'(1));
        check("post_reset_entry", 128'(entry), 128'(0));

        run_one("aligned", 64'h1000, 10'd32, 10'h05, 8'd0, 5'd0, 5'd31, 64'h1000);
        run_one("offset", 64'h1074, 10'd8, 10'h3a, 8'd1, 5'd29, 5'd4,
`ifdef AR_ADDR_ALIGN_EN
                64'h1000);
`else
                64'h1074);
`endif
        run_one("maxlen", 64'h20007C, 10'd0, 10'h3ff, 8'd32, 5'd31, 5'd30,
`ifdef AR_ADDR_ALIGN_EN
                64'h200000);
`else
                64'h20007C);
`endif
        run_one("align", 64'h10C, 10'd4, 10'h11, 8'd0, 5'd3, 5'd6,
`ifdef AR_ADDR_ALIGN_EN
                64'h100);
`else
                64'h10C);
`endif

        // Backpressure: full held for five PUSH cycles, then released.
        @(posedge clk); #1;
        fifo_full = 1'b1;
        a_tmp = {$urandom, $urandom};
        drive_req(a_tmp, 10'($urandom), 10'($urandom));
        e_tmp = exp_entry(req_addr, req_length, req_tag, req_rid, req_tc, req_fbe, req_lbe);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_strobe", 128'(wr_inc), 128'(0));
            check("bp_entry", 128'(entry), 128'(e_tmp));
            @(posedge clk); #1;
        end
        fifo_full = 1'b0;
        @(negedge clk);
        check("bp_release", 128'(wr_inc), 128'(1));
        check("bp_release_entry", 128'(entry), 128'(e_tmp));
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_once", 128'(wr_inc), 128'(0));
        check("bp_ready", 128'(req_ready), 128'(1));

        // Reset while stalled in PUSH discards the request.
        @(posedge clk); #1;
        fifo_full = 1'b1;
        drive_req({$urandom, $urandom}, 10'($urandom), 10'($urandom));
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        fifo_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_strobe", 128'(wr_inc), 128'(0));
            check("rst_mid_entry", 128'(entry), 128'(0));
            check("rst_mid_ready", 128'(req_ready), 128'(1));
        end

        // Random traffic; the monitor checks every cycle.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            fifo_full  = ($urandom_range(0, 3) == 0);
            req_valid  = 1'($urandom_range(0, 1));
            req_addr   = {$urandom, $urandom};
            req_length = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom);
            req_tag    = 10'($urandom);
            req_rid    = 16'($urandom);
            req_tc     = 3'($urandom);
            req_fbe    = 4'($urandom);
            req_lbe    = 4'($urandom);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < 10 && busy; i++) @(posedge clk);
        @(negedge clk);
        check("drain_ready", 128'(req_ready), 128'(1));
        check("drain_busy", 128'(busy), 128'(0));

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
